axilite_s_regs: RTL and testbench
=================================

// Module: axilite_s_regs
// PURPOSE
//  AXI4-Lite slave (responder) with a bank of NUM_REGS 32-bit registers; peer of axilite_m.
//  Accepts single-beat writes and reads, one transaction outstanding, and returns OKAY/SLVERR.
//  Sits at the far end of an axilite_m link as the target register block.
// PARAMETERS
//  ADDR_W    32            address width; word index = addr[ADDR_W-1:2], addr[1:0] ignored
//  NUM_REGS  16            number of registers; index 0 = read-only ID register
//  ID_VALUE  32'hA11E_0001 value read from register 0
// PORTS
//  s_axi_aclk     in   1       clock, all logic on rising edge
//  s_axi_aresetn  in   1       asynchronous active-low reset
//  s_axi_awvalid  in   1       write address valid
//  s_axi_awready  out  1       write address ready
//  s_axi_awaddr   in   ADDR_W  write byte address
//  s_axi_wvalid   in   1       write data valid
//  s_axi_wready   out  1       write data ready
//  s_axi_wdata    in   32      write data
//  s_axi_wstrb    in   4       byte enables, bit n -> wdata[8n+7:8n]
//  s_axi_bvalid   out  1       write response valid
//  s_axi_bready   in   1       write response ready
//  s_axi_bresp    out  2       00 OKAY, 10 SLVERR
//  s_axi_arvalid  in   1       read address valid
//  s_axi_arready  out  1       read address ready
//  s_axi_araddr   in   ADDR_W  read byte address
//  s_axi_rvalid   out  1       read data valid
//  s_axi_rready   in   1       read data ready
//  s_axi_rdata    out  32      read data
//  s_axi_rresp    out  2       00 OKAY, 10 SLVERR
// BEHAVIOUR
//  Reset (async, aresetn=0): state IDLE, all ready/valid outputs 0, bresp/rresp/rdata 0,
//   registers 1..NUM_REGS-1 cleared to 0, aw_got/w_got cleared. Reset mid-transaction aborts it.
//  FSM states: IDLE, WCAP, WRESP, RACC, RDATA.
//  IDLE: all readies 0. awvalid|wvalid -> WCAP (writes win over simultaneous arvalid);
//   else arvalid -> RACC.
//  WCAP: awready = !aw_got, wready = !w_got (decoded from state/flags). AW and W accepted in any
//   order or the same edge; awaddr/wdata/wstrb latched on their handshakes. On the edge both are
//   held: commit write, bvalid<=1, bresp set, -> WRESP. Min awvalid(IDLE)->bvalid = 2 cycles.
//  WRESP: bvalid,bresp held stable until bready; on bvalid&bready edge bvalid<=0, flags clear, -> IDLE.
//  RACC: arready=1 one cycle; araddr captured, rdata/rresp registered, rvalid<=1, -> RDATA.
//   Min arvalid(IDLE)->rvalid = 2 cycles.
//  RDATA: rvalid,rdata,rresp held until rready; on handshake rvalid<=0, rdata<=0, -> IDLE.
//  Decode: idx>=NUM_REGS -> SLVERR, write discarded, rdata=0. Write to idx 0 -> SLVERR, discarded;
//   read idx 0 -> ID_VALUE, OKAY. Valid write updates only bytes with wstrb=1; wstrb=0 is OKAY, no change.
//  No back-to-back: at least one IDLE cycle between transactions; valid never depends on ready.
// TESTING
//  1 write addr 0x04 data 0x1234_5678 strb F, bready=1 -> bvalid 2 cycles later, bresp 00; read 0x04 -> 0x1234_5678 00
//  2 wstrb 4'b0101, data 0xAABB_CCDD onto 0x1234_5678 at 0x08 -> read 0x08 = 0x12BB_56DD
//  3 W valid 3 cycles before AW, then AW -> single write committed, one bvalid pulse, bresp 00
//  4 write 0x00 -> bresp 10, read 0x00 = 0xA11E_0001 00; read 0x40 (NUM_REGS=16) -> rdata 0, rresp 10
//  5 awvalid and arvalid same cycle -> write completes first, then read returns new data
//  6 bready held 0 for 7 cycles -> bvalid/bresp stable; aresetn pulsed mid-WRESP -> bvalid 0, regs 0

Source files
------------

// File: rtl/axilite_s_regs_if.sv
// AXI4-Lite link between an axilite_m master and the axilite_s_regs register block.
interface axilite_s_regs_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic              wvalid;
  logic              wready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic              rvalid;
  logic              rready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axilite_s_regs.sv
// AXI4-Lite register-bank slave: read-only ID at index 0, byte-strobed R/W registers above it,
// one transaction in flight, SLVERR on ID writes and out-of-range indices.
module axilite_s_regs #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned NUM_REGS = 16,
  parameter logic [31:0] ID_VALUE = 32'hA11E_0001
) (
  input  logic            s_axi_aclk,
  input  logic            s_axi_aresetn,
  axilite_s_regs_if.slave s_axi
);

  localparam int unsigned IDX_W  = ADDR_W - 2;
  localparam int unsigned REG_AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  typedef enum logic [2:0] {IDLE, WCAP, WRESP, RACC, RDATA} state_t;

  state_t            state;
  logic              aw_got, w_got;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [31:0]       w_data_q;
  logic [3:0]        w_strb_q;
  logic [31:0]       regs [NUM_REGS];

  logic              awready_q, wready_q, arready_q;
  logic              bvalid_q, rvalid_q;
  logic [1:0]        bresp_q, rresp_q;
  logic [31:0]       rdata_q;

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.arready = arready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rdata   = rdata_q;

  // Effective write payload: latched copy if already accepted, else the beat landing this edge.
  logic              aw_hs, w_hs, aw_done, w_done;
  logic [ADDR_W-1:0] eff_addr;
  logic [31:0]       eff_data;
  logic [3:0]        eff_strb;
  logic [IDX_W-1:0]  w_idx, r_idx;
  logic              w_ok, r_in_range;
  logic [31:0]       rd_val;

  assign aw_hs    = s_axi.awvalid & awready_q;
  assign w_hs     = s_axi.wvalid & wready_q;
  assign aw_done  = aw_got | aw_hs;
  assign w_done   = w_got | w_hs;
  assign eff_addr = aw_got ? aw_addr_q : s_axi.awaddr;
  assign eff_data = w_got ? w_data_q : s_axi.wdata;
  assign eff_strb = w_got ? w_strb_q : s_axi.wstrb;

  assign w_idx      = eff_addr[ADDR_W-1:2];
  assign w_ok       = (w_idx != '0) && (w_idx < IDX_W'(NUM_REGS));
  assign r_idx      = s_axi.araddr[ADDR_W-1:2];
  assign r_in_range = r_idx < IDX_W'(NUM_REGS);
  assign rd_val     = !r_in_range    ? 32'h0 :
                      (r_idx == '0)  ? ID_VALUE :
                                       regs[r_idx[REG_AW-1:0]];

  // Byte offset bits carry no meaning for word registers.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{eff_addr[1:0], s_axi.araddr[1:0]};

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state     <= IDLE;
      aw_got    <= 1'b0;
      w_got     <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= OKAY;
      rdata_q   <= '0;
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (s_axi.awvalid || s_axi.wvalid) begin
            state     <= WCAP;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end else if (s_axi.arvalid) begin
            state     <= RACC;
            arready_q <= 1'b1;
          end
        end
        WCAP: begin
          if (aw_hs) begin
            aw_got    <= 1'b1;
            aw_addr_q <= s_axi.awaddr;
            awready_q <= 1'b0;
          end
          if (w_hs) begin
            w_got    <= 1'b1;
            w_data_q <= s_axi.wdata;
            w_strb_q <= s_axi.wstrb;
            wready_q <= 1'b0;
          end
          if (aw_done && w_done) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            if (w_ok) begin
              for (int b = 0; b < 4; b++) begin
                if (eff_strb[b]) regs[w_idx[REG_AW-1:0]][8*b +: 8] <= eff_data[8*b +: 8];
              end
            end
            bresp_q  <= w_ok ? OKAY : SLVERR;
            bvalid_q <= 1'b1;
            state    <= WRESP;
          end
        end
        WRESP: begin
          if (s_axi.bready) begin
            bvalid_q <= 1'b0;
            aw_got   <= 1'b0;
            w_got    <= 1'b0;
            state    <= IDLE;
          end
        end
        RACC: begin
          arready_q <= 1'b0;
          rdata_q   <= rd_val;
          rresp_q   <= r_in_range ? OKAY : SLVERR;
          rvalid_q  <= 1'b1;
          state     <= RDATA;
        end
        RDATA: begin
          if (s_axi.rready) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axilite_s_regs.sv
// Directed bench for axilite_s_regs: strobes, AW/W ordering, decode errors, arbitration, reset.
module tb_axilite_s_regs;

  localparam int LIMIT = 40;

  logic clk = 1'b0;
  logic aresetn;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  axilite_s_regs_if #(.ADDR_W(32)) bus ();

  axilite_s_regs #(.ADDR_W(32), .NUM_REGS(16), .ID_VALUE(32'hA11E_0001)) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (aresetn),
    .s_axi         (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp, output int lat);
    logic aw_f, w_f;
    int   n;
    bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
    n = 0;
    while (!bus.bvalid && n < LIMIT) begin
      aw_f = bus.awvalid & bus.awready;
      w_f  = bus.wvalid & bus.wready;
      @(posedge clk); #1;
      n++;
      if (aw_f) bus.awvalid = 1'b0;
      if (w_f)  bus.wvalid  = 1'b0;
    end
    chk("wr_bvalid_seen", 32'(bus.bvalid), 32'd1);
    resp = bus.bresp;
    lat  = n;
    @(posedge clk); #1;
    bus.bready = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output int lat);
    logic ar_f;
    int   n;
    bus.araddr = addr; bus.arvalid = 1'b1; bus.rready = 1'b1;
    n = 0;
    while (!bus.rvalid && n < LIMIT) begin
      ar_f = bus.arvalid & bus.arready;
      @(posedge clk); #1;
      n++;
      if (ar_f) bus.arvalid = 1'b0;
    end
    chk("rd_rvalid_seen", 32'(bus.rvalid), 32'd1);
    data = bus.rdata;
    resp = bus.rresp;
    lat  = n;
    @(posedge clk); #1;
    bus.rready = 1'b0; bus.arvalid = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  rsp;
    int          lat, pulses, b_cyc, r_cyc, n;
    logic        aw_f, w_f, ar_f;

    bus.awvalid = 1'b0; bus.awaddr = '0; bus.wvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
    bus.bready = 1'b0; bus.arvalid = 1'b0; bus.araddr = '0; bus.rready = 1'b0;
    aresetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", 32'(bus.awready), 32'd0);
    chk("rst_wready",  32'(bus.wready),  32'd0);
    chk("rst_arready", 32'(bus.arready), 32'd0);
    chk("rst_bvalid",  32'(bus.bvalid),  32'd0);
    chk("rst_rvalid",  32'(bus.rvalid),  32'd0);
    chk("rst_bresp",   32'(bus.bresp),   32'd0);
    chk("rst_rresp",   32'(bus.rresp),   32'd0);
    chk("rst_rdata",   bus.rdata,        32'd0);
    @(negedge clk) aresetn = 1'b1;
    @(posedge clk); #1;

    // 1: full write, latency 2, read back
    axi_write(32'h04, 32'h1234_5678, 4'hF, rsp, lat);
    chk("t1_wr_lat",  32'(lat), 32'd2);
    chk("t1_bresp",   32'(rsp), 32'd0);
    axi_read(32'h04, rd, rsp, lat);
    chk("t1_rd_lat",  32'(lat), 32'd2);
    chk("t1_rdata",   rd,       32'h1234_5678);
    chk("t1_rresp",   32'(rsp), 32'd0);

    // 2: partial strobe merge
    axi_write(32'h08, 32'h1234_5678, 4'hF, rsp, lat);
    axi_write(32'h08, 32'hAABB_CCDD, 4'b0101, rsp, lat);
    chk("t2_bresp",   32'(rsp), 32'd0);
    axi_read(32'h08, rd, rsp, lat);
    chk("t2_rdata",   rd,       32'h12BB_56DD);

    // 3: W leads AW by three cycles
    bus.wdata = 32'hCAFE_F00D; bus.wstrb = 4'hF; bus.wvalid = 1'b1; bus.bready = 1'b1;
    repeat (3) begin
      w_f = bus.wvalid & bus.wready;
      @(posedge clk); #1;
      if (w_f) bus.wvalid = 1'b0;
    end
    chk("t3_no_early_b", 32'(bus.bvalid), 32'd0);
    bus.awaddr = 32'h0C; bus.awvalid = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      aw_f = bus.awvalid & bus.awready;
      w_f  = bus.wvalid & bus.wready;
      @(posedge clk); #1;
      if (aw_f) bus.awvalid = 1'b0;
      if (w_f)  bus.wvalid  = 1'b0;
      if (bus.bvalid) begin
        pulses++;
        chk("t3_bresp", 32'(bus.bresp), 32'd0);
      end
    end
    bus.bready = 1'b0;
    chk("t3_b_pulses", 32'(pulses), 32'd1);
    axi_read(32'h0C, rd, rsp, lat);
    chk("t3_rdata", rd, 32'hCAFE_F00D);

    // 4: decode errors, ID register, zero strobe, ignored byte offset
    axi_write(32'h00, 32'hFFFF_FFFF, 4'hF, rsp, lat);
    chk("t4_wr_id_resp", 32'(rsp), 32'd2);
    axi_read(32'h00, rd, rsp, lat);
    chk("t4_id_data", rd,       32'hA11E_0001);
    chk("t4_id_resp", 32'(rsp), 32'd0);
    axi_read(32'h40, rd, rsp, lat);
    chk("t4_oor_data", rd,       32'd0);
    chk("t4_oor_resp", 32'(rsp), 32'd2);
    axi_write(32'h40, 32'h1111_1111, 4'hF, rsp, lat);
    chk("t4_wr_oor_resp", 32'(rsp), 32'd2);
    axi_write(32'h04, 32'hDEAD_DEAD, 4'h0, rsp, lat);
    chk("t4_strb0_resp", 32'(rsp), 32'd0);
    axi_read(32'h07, rd, rsp, lat);
    chk("t4_strb0_keep", rd, 32'h1234_5678);

    // 5: write and read requested together; write wins
    bus.awaddr = 32'h10; bus.wdata = 32'h5555_AAAA; bus.wstrb = 4'hF; bus.araddr = 32'h10;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
    bus.bready = 1'b1; bus.rready = 1'b1;
    b_cyc = 0; r_cyc = 0; n = 0; rd = '0;
    while (r_cyc == 0 && n < LIMIT) begin
      aw_f = bus.awvalid & bus.awready;
      w_f  = bus.wvalid & bus.wready;
      ar_f = bus.arvalid & bus.arready;
      @(posedge clk); #1;
      n++;
      if (aw_f) bus.awvalid = 1'b0;
      if (w_f)  bus.wvalid  = 1'b0;
      if (ar_f) bus.arvalid = 1'b0;
      if (bus.bvalid && b_cyc == 0) b_cyc = n;
      if (bus.rvalid) begin
        r_cyc = n;
        rd    = bus.rdata;
      end
    end
    @(posedge clk); #1;
    bus.bready = 1'b0; bus.rready = 1'b0; bus.arvalid = 1'b0;
    chk("t5_b_cycle", 32'(b_cyc), 32'd2);
    chk("t5_r_cycle", 32'(r_cyc), 32'd5);
    chk("t5_rdata",   rd,         32'h5555_AAAA);

    // 6: stalled response, then reset inside WRESP
    bus.awaddr = 32'h14; bus.wdata = 32'h0BAD_BEEF; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
    n = 0;
    while (!bus.bvalid && n < LIMIT) begin
      aw_f = bus.awvalid & bus.awready;
      w_f  = bus.wvalid & bus.wready;
      @(posedge clk); #1;
      n++;
      if (aw_f) bus.awvalid = 1'b0;
      if (w_f)  bus.wvalid  = 1'b0;
    end
    chk("t6_bvalid_up", 32'(bus.bvalid), 32'd1);
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      chk("t6_bvalid_hold", 32'(bus.bvalid), 32'd1);
      chk("t6_bresp_hold",  32'(bus.bresp),  32'd0);
    end
    aresetn = 1'b0;
    #1;
    chk("t6_rst_bvalid", 32'(bus.bvalid), 32'd0);
    @(posedge clk);
    @(negedge clk) aresetn = 1'b1;
    @(posedge clk); #1;
    axi_read(32'h04, rd, rsp, lat);
    chk("t6_reg04_clr", rd, 32'd0);
    axi_read(32'h14, rd, rsp, lat);
    chk("t6_reg14_clr", rd, 32'd0);
    axi_read(32'h00, rd, rsp, lat);
    chk("t6_id_after", rd, 32'hA11E_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
